// File: rtl/ofdm_rx_pkg.sv
// Shared constants, output FSM state type and the deinterleave index helper
// for the QPSK demap/deinterleave stage of the OFDM receiver.
package ofdm_rx_pkg;

   localparam int unsigned N_SC       = 48;
   localparam int unsigned N_CBPS     = 96;
   localparam int unsigned N_BPSC     = 2;
   localparam int unsigned DEINT_COLS = 16;
   localparam int unsigned DEINT_ROWS = 6;

   typedef enum logic {IDLE, DRAIN} demap_state_t;

   // Output position k reads stored bit 6*(k%16)+k/16.
   function automatic logic [6:0] deint_idx(input logic [6:0] k);
      int unsigned kk;
      kk = 32'(k);
      return 7'(DEINT_ROWS * (kk % DEINT_COLS) + kk / DEINT_COLS);
   endfunction

endpackage

// File: rtl/pingpong_bitbuf.sv
// Two-bank symbol buffer (N_CBPS hard bits per bank) with per-bank full flags.
// With SOFT_LLR_EN defined, a signed SOFT_W-bit soft value is kept per bit.
module pingpong_bitbuf
   import ofdm_rx_pkg::*;
`ifdef SOFT_LLR_EN
#(
   parameter int unsigned SOFT_W = 4
)
`endif
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       wr_en_i,
   input  logic       wr_sel_i,
   input  logic [5:0] wr_pos_i,
   input  logic [1:0] wr_bits_i,
   input  logic       wr_last_i,
   input  logic       rd_sel_i,
   input  logic [6:0] rd_idx_i,
   input  logic       rd_clr_i,
   output logic [1:0] full_o,
   output logic       rd_bit_o
`ifdef SOFT_LLR_EN
   ,
   input  logic signed [SOFT_W-1:0] wr_soft0_i,
   input  logic signed [SOFT_W-1:0] wr_soft1_i,
   output logic signed [SOFT_W-1:0] rd_soft_o
`endif
);

   logic [N_CBPS-1:0] bank_q [2];
   logic [1:0]        full_q, full_d;
   logic [6:0]        base;

   assign base = 7'(32'(wr_pos_i) * N_BPSC);

   // Set and clear never address the same bank, so both may apply together.
   always_comb begin
      full_d = full_q;
      if (wr_en_i && wr_last_i) full_d[wr_sel_i] = 1'b1;
      if (rd_clr_i)             full_d[rd_sel_i] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)     full_q <= '0;
      else if (en_i) full_q <= full_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && en_i && wr_en_i) begin
         bank_q[wr_sel_i][base]        <= wr_bits_i[0];
         bank_q[wr_sel_i][base + 7'd1] <= wr_bits_i[1];
      end
   end

   assign rd_bit_o = bank_q[rd_sel_i][rd_idx_i];
   assign full_o   = full_q;

`ifdef SOFT_LLR_EN
   logic signed [SOFT_W-1:0] soft_q [2][N_CBPS];

   always_ff @(posedge clk_i) begin
      if (!rst_i && en_i && wr_en_i) begin
         soft_q[wr_sel_i][base]        <= wr_soft0_i;
         soft_q[wr_sel_i][base + 7'd1] <= wr_soft1_i;
      end
   end

   assign rd_soft_o = soft_q[rd_sel_i][rd_idx_i];
`endif

endmodule

// File: rtl/qpsk_demap_deint.sv
// QPSK hard demapper into a ping-pong symbol buffer, streamed out one bit per
// handshake in deinterleaved order. Define SOFT_LLR_EN to add out_soft.
module qpsk_demap_deint
   import ofdm_rx_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned N_SC   = ofdm_rx_pkg::N_SC
`ifdef SOFT_LLR_EN
   ,
   parameter int unsigned SOFT_W = 4
`endif
)(
   input  logic                     CLK,
   input  logic                     s_RST,
   input  logic                     enable,
   input  logic                     in_strobe,
   input  logic                     data_en,
   input  logic signed [DATA_W-1:0] I_in,
   input  logic signed [DATA_W-1:0] Q_in,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic                     out_bit,
   output logic                     sym_done,
   output logic                     overflow
`ifdef SOFT_LLR_EN
   ,
   output logic signed [SOFT_W-1:0] out_soft
`endif
);

   localparam logic [5:0] LAST_SAMPLE = 6'(N_SC - 1);
   localparam logic [6:0] LAST_BIT    = 7'(N_CBPS - 1);

   logic         accept, start_ovf, skip;
   logic [1:0]   full;
   logic         wr_bank_q, wr_bank_d;
   logic [5:0]   wr_cnt_q, wr_cnt_d;
   logic         drop_q, drop_d;
   logic         ovf_q, ovf_d;
   logic         wr_pend_q, wr_pend_d;
   logic         wr_pbank_q, wr_pbank_d;
   logic [5:0]   wr_ppos_q, wr_ppos_d;
   logic [1:0]   wr_pbits_q, wr_pbits_d;
   logic         wr_plast_q, wr_plast_d;
   demap_state_t state_q, state_d;
   logic         rd_bank_q, rd_bank_d;
   logic [6:0]   rd_cnt_q, rd_cnt_d;
   logic         rd_clr, rd_bit;

   assign accept    = enable && in_strobe && data_en;
   assign start_ovf = accept && (wr_cnt_q == '0) && full[wr_bank_q];

   // Demapped bits go through one register stage before the buffer write,
   // so full[] rises one cycle after the last accept.
   always_comb begin
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      drop_d     = drop_q;
      ovf_d      = ovf_q;
      skip       = drop_q || start_ovf;
      wr_pend_d  = accept && !skip;
      wr_pbank_d = wr_bank_q;
      wr_ppos_d  = wr_cnt_q;
      wr_pbits_d = {Q_in >= 0, I_in >= 0};
      wr_plast_d = 1'b0;
      if (accept) begin
         if (start_ovf) begin
            drop_d = 1'b1;
            ovf_d  = 1'b1;
         end
         if (wr_cnt_q == LAST_SAMPLE) begin
            wr_cnt_d   = '0;
            drop_d     = 1'b0;
            wr_plast_d = !skip;
            if (!skip) wr_bank_d = ~wr_bank_q;
         end else begin
            wr_cnt_d = wr_cnt_q + 6'd1;
         end
      end else if (enable && !data_en && wr_cnt_q != '0) begin
         wr_cnt_d = '0;
         drop_d   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (s_RST) begin
         wr_cnt_q   <= '0;
         wr_bank_q  <= 1'b0;
         drop_q     <= 1'b0;
         ovf_q      <= 1'b0;
         wr_pend_q  <= 1'b0;
         wr_pbank_q <= 1'b0;
         wr_ppos_q  <= '0;
         wr_pbits_q <= '0;
         wr_plast_q <= 1'b0;
      end else if (enable) begin
         wr_cnt_q   <= wr_cnt_d;
         wr_bank_q  <= wr_bank_d;
         drop_q     <= drop_d;
         ovf_q      <= ovf_d;
         wr_pend_q  <= wr_pend_d;
         wr_pbank_q <= wr_pbank_d;
         wr_ppos_q  <= wr_ppos_d;
         wr_pbits_q <= wr_pbits_d;
         wr_plast_q <= wr_plast_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_clr    = 1'b0;
      out_valid = 1'b0;
      sym_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (full[rd_bank_q]) begin
               state_d  = DRAIN;
               rd_cnt_d = '0;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (rd_cnt_q == LAST_BIT) begin
                  state_d   = IDLE;
                  rd_bank_d = ~rd_bank_q;
                  rd_clr    = 1'b1;
                  sym_done  = enable;
               end else begin
                  rd_cnt_d = rd_cnt_q + 7'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (s_RST) begin
         state_q   <= IDLE;
         rd_cnt_q  <= '0;
         rd_bank_q <= 1'b0;
      end else if (enable) begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   assign out_bit  = (state_q == DRAIN) ? rd_bit : 1'b0;
   assign overflow = ovf_q;

`ifdef SOFT_LLR_EN
   localparam logic signed [DATA_W-1:0] SOFT_MAX = DATA_W'((1 << (SOFT_W - 1)) - 1);

   function automatic logic signed [SOFT_W-1:0] soft_sat(input logic signed [DATA_W-1:0] x);
      logic signed [DATA_W-1:0] sh;
      sh = x >>> (DATA_W - SOFT_W);
      if (sh > SOFT_MAX)  return SOFT_W'(SOFT_MAX);
      if (sh < -SOFT_MAX) return SOFT_W'(-SOFT_MAX);
      return SOFT_W'(sh);
   endfunction

   logic signed [SOFT_W-1:0] wr_psoft0_q, wr_psoft1_q, rd_soft;

   always_ff @(posedge CLK) begin
      if (s_RST) begin
         wr_psoft0_q <= '0;
         wr_psoft1_q <= '0;
      end else if (enable) begin
         wr_psoft0_q <= soft_sat(I_in);
         wr_psoft1_q <= soft_sat(Q_in);
      end
   end

   assign out_soft = (state_q == DRAIN) ? rd_soft : '0;
`endif

   pingpong_bitbuf
`ifdef SOFT_LLR_EN
      #(.SOFT_W(SOFT_W))
`endif
   u_buf (
      .clk_i     (CLK),
      .rst_i     (s_RST),
      .en_i      (enable),
      .wr_en_i   (wr_pend_q),
      .wr_sel_i  (wr_pbank_q),
      .wr_pos_i  (wr_ppos_q),
      .wr_bits_i (wr_pbits_q),
      .wr_last_i (wr_plast_q),
      .rd_sel_i  (rd_bank_q),
      .rd_idx_i  (deint_idx(rd_cnt_q)),
      .rd_clr_i  (rd_clr),
      .full_o    (full),
      .rd_bit_o  (rd_bit)
`ifdef SOFT_LLR_EN
      ,
      .wr_soft0_i (wr_psoft0_q),
      .wr_soft1_i (wr_psoft1_q),
      .rd_soft_o  (rd_soft)
`endif
   );

endmodule

// File: tb/tb_qpsk_demap_deint.sv
// Directed bench for qpsk_demap_deint; soft-output checks compile only when
// SOFT_LLR_EN is defined.
module tb_qpsk_demap_deint;

   localparam int unsigned DW = 16;

   logic                 CLK = 1'b0;
   logic                 s_RST, enable, in_strobe, data_en, out_ready;
   logic signed [DW-1:0] I_in, Q_in;
   logic                 out_valid, out_bit, sym_done, overflow;
`ifdef SOFT_LLR_EN
   logic signed [3:0]    out_soft;
   logic signed [3:0]    soft_got [96];
`endif

   int unsigned          n_cmp = 0;
   int unsigned          n_bad = 0;
   logic signed [DW-1:0] si [48];
   logic signed [DW-1:0] sq [48];
   logic [95:0]          exp_a, exp_b;

   always #5 CLK = ~CLK;

   qpsk_demap_deint #(.DATA_W(DW)) dut (
      .CLK       (CLK),
      .s_RST     (s_RST),
      .enable    (enable),
      .in_strobe (in_strobe),
      .data_en   (data_en),
      .I_in      (I_in),
      .Q_in      (Q_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .sym_done  (sym_done),
      .overflow  (overflow)
`ifdef SOFT_LLR_EN
      ,
      .out_soft  (out_soft)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      s_RST = 1'b1;
      tick();
      tick();
      s_RST = 1'b0;
   endtask

   task automatic send_sym(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         in_strobe = 1'b1;
         data_en   = 1'b1;
         I_in      = si[i];
         Q_in      = sq[i];
         tick();
      end
      in_strobe = 1'b0;
      data_en   = 1'b0;
   endtask

   task automatic fill_const(input logic signed [DW-1:0] iv, input logic signed [DW-1:0] qv);
      for (int unsigned i = 0; i < 48; i++) begin
         si[i] = iv;
         sq[i] = qv;
      end
   endtask

   task automatic fill_rand();
      for (int unsigned i = 0; i < 48; i++) begin
         si[i] = 16'($urandom);
         sq[i] = 16'($urandom);
      end
   endtask

   function automatic logic [95:0] model_seq();
      logic [95:0] seq;
      int unsigned j;
      for (int unsigned k = 0; k < 96; k++) begin
         j = 6 * (k % 16) + k / 16;
         seq[k] = (j % 2 == 0) ? (si[j / 2] >= 0) : (sq[j / 2] >= 0);
      end
      return seq;
   endfunction

   // Checks every presented bit (stalled or not) against the expected position.
   task automatic drain(input logic [95:0] want, input logic [3:0] pat, input string name);
      int unsigned n   = 0;
      int unsigned cyc = 0;
      while (n < 96 && cyc < 600) begin
         out_ready = pat[cyc % 4];
         @(negedge CLK);
         if (out_valid) begin
            chk($sformatf("%s_bit%0d", name, n), 32'(out_bit), 32'(want[n]));
            if (out_ready) begin
               chk($sformatf("%s_done%0d", name, n), 32'(sym_done), 32'(n == 95));
`ifdef SOFT_LLR_EN
               soft_got[n] = out_soft;
`endif
               n++;
            end
         end
         tick();
         cyc++;
      end
      if (n != 96) chk($sformatf("%s_timeout", name), n, 96);
      out_ready = 1'b0;
   endtask

   task automatic idle_check(input string name, input int unsigned cycles);
      int unsigned cnt = 0;
      out_ready = 1'b1;
      for (int unsigned c = 0; c < cycles; c++) begin
         @(negedge CLK);
         if (out_valid) cnt++;
         tick();
      end
      chk(name, cnt, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [95:0] hand;

      enable    = 1'b1;
      in_strobe = 1'b0;
      data_en   = 1'b0;
      I_in      = '0;
      Q_in      = '0;
      out_ready = 1'b0;
      do_reset();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_bit",   32'(out_bit),   0);
      chk("rst_done",  32'(sym_done),  0);
      chk("rst_ovf",   32'(overflow),  0);

      // I=+100, Q=-100: bits alternate per 16-bit group starting with 1.
      for (int unsigned k = 0; k < 96; k++) hand[k] = ((k / 16) % 2 == 0);
      fill_const(16'sd100, -16'sd100);
      send_sym(48);
      chk("lat_e0", 32'(out_valid), 0);
      tick();
      chk("lat_e1", 32'(out_valid), 0);
      tick();
      chk("lat_e2", 32'(out_valid), 1);
      drain(hand, 4'b1111, "t1");
      @(negedge CLK);
      chk("t1_after_valid", 32'(out_valid), 0);
      tick();

      hand = '1;
      hand[0] = 1'b0;
      fill_const(16'sd100, 16'sd100);
      si[0] = -16'sd5;
      send_sym(48);
      drain(hand, 4'b1111, "t2a");

      hand = '1;
      hand[95] = 1'b0;
      fill_const(16'sd100, 16'sd100);
      sq[47] = -16'sd5;
      send_sym(48);
      drain(hand, 4'b1111, "t2b");

      // Ready pattern 1,0,0,1 repeating.
      for (int unsigned k = 0; k < 96; k++) hand[k] = ((k / 16) % 2 == 0);
      fill_const(16'sd100, -16'sd100);
      send_sym(48);
      drain(hand, 4'b1001, "t4");

      // Two buffered symbols while stalled, third is dropped.
      out_ready = 1'b0;
      fill_rand();
      exp_a = model_seq();
      send_sym(48);
      fill_rand();
      exp_b = model_seq();
      send_sym(48);
      tick();
      tick();
      chk("t3_ovf_two", 32'(overflow), 0);
      chk("t3_stalled_valid", 32'(out_valid), 1);
      fill_rand();
      send_sym(48);
      tick();
      chk("t3_ovf_three", 32'(overflow), 1);
      drain(exp_a, 4'b1111, "t3a");
      drain(exp_b, 4'b1111, "t3b");
      idle_check("t3_no_third", 150);
      chk("t3_ovf_sticky", 32'(overflow), 1);

      do_reset();
      chk("rst2_ovf",   32'(overflow),  0);
      chk("rst2_valid", 32'(out_valid), 0);

      // Partial symbol of 20 samples, then a complete one.
      fill_const(-16'sd1000, -16'sd1000);
      send_sym(20);
      tick();
      fill_rand();
      exp_a = model_seq();
      send_sym(48);
      drain(exp_a, 4'b1111, "t5");
      idle_check("t5_only_one", 120);
      chk("t5_ovf", 32'(overflow), 0);

      // Reset in the middle of a drain with a second symbol buffered.
      fill_rand();
      send_sym(48);
      fill_rand();
      send_sym(48);
      out_ready = 1'b1;
      for (int unsigned c = 0; c < 30; c++) tick();
      s_RST = 1'b1;
      tick();
      chk("rstmid_valid", 32'(out_valid), 0);
      chk("rstmid_done",  32'(sym_done),  0);
      s_RST = 1'b0;
      idle_check("rstmid_no_output", 250);
      chk("rstmid_ovf", 32'(overflow), 0);

`ifdef SOFT_LLR_EN
      do_reset();
      fill_const(16'sd100, 16'sd100);
      si[0] = 16'sd32767;
      si[1] = -16'sd32768;
      si[2] = 16'sd0;
      exp_a = model_seq();
      send_sym(48);
      drain(exp_a, 4'b1111, "soft");
      chk("soft_pos_max", 32'(soft_got[0]),  32'(7));
      chk("soft_neg_max", 32'(soft_got[32]), 32'(-7));
      chk("soft_zero",    32'(soft_got[64]), 32'(0));
      chk("soft_zero_bit", 32'(exp_a[64]) & 32'(soft_got[64] == 4'sd0), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
